// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter:
// FSM state encoding and default geometry / timeout values.
package mem_arb_pkg;

    localparam int ADDR_W_DEF      = 10;
    localparam int DATA_W_DEF      = 20;
    localparam int TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_arbiter2_if.sv
// Requester and memory bus bundle for mem_arbiter2.
// slave: arbiter view; master: requesters + memory view.
interface mem_arbiter2_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 20
);
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        ack;
    logic [1:0]        err;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1,
        input  mem_rdata, mem_ready,
        output ack, err, rdata, busy,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1,
        output mem_rdata, mem_ready,
        input  ack, err, rdata, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: one-hot gnt_o from req_i.
// Ports: req_i[1:0], last_grant_i (index of last winner), gnt_o[1:0].
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Contention: the port that did not win last time goes now.
            2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end
endmodule

// File: rtl/mem_arbiter2.sv
// Serialises two requesters onto one memory handshake (IDLE/ISSUE/BUSY/DONE).
// Ports: clk, reset_n (sync, active low), bus (mem_arbiter2_if.slave).
module mem_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    mem_arbiter2_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

    state_e            state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic              seen_low_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [1:0]        ack_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [1:0]        gnt;

    rr_arbiter2 u_rr (
        .req_i        (bus.req),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            seen_low_q   <= 1'b0;
            cnt_q        <= '0;
            ack_q        <= 2'b00;
            err_q        <= 2'b00;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            ack_q     <= 2'b00;
            err_q     <= 2'b00;
            mem_req_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|gnt && bus.mem_ready) begin
                        grant_q     <= gnt[1];
                        mem_we_q    <= gnt[1] ? bus.we[1] : bus.we[0];
                        mem_addr_q  <= gnt[1] ? bus.addr1 : bus.addr0;
                        mem_wdata_q <= gnt[1] ? bus.wdata1 : bus.wdata0;
                        mem_req_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    seen_low_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= S_BUSY;
                end
                S_BUSY: begin
                    cnt_q <= cnt_d;
                    if (!bus.mem_ready) begin
                        seen_low_q <= 1'b1;
                    end
                    // Ready only counts as completion after it has
                    // been seen low, so a stale ready is ignored.
                    if (seen_low_q && bus.mem_ready) begin
                        if (!mem_we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= S_DONE;
                    end else if (cnt_d == CNT_LIMIT) begin
                        ack_q[grant_q] <= 1'b1;
                        err_q[grant_q] <= 1'b1;
                        state_q        <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_grant_q <= grant_q;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2 with a half-word memory model.
// Memory drops mem_ready for 2 cycles after each mem_req.
module tb_mem_arbiter2;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    mem_arbiter2_if #(.ADDR_W(10), .DATA_W(20)) bus ();

    mem_arbiter2 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [9:0]  m [0:1023] = '{default: 10'd0};
    logic [19:0] mrd = 20'd0;
    int lowcnt = 0;
    bit force_low = 1'b0;
    bit no_drop = 1'b0;
    int mreq_cnt = 0;
    int mreq_double = 0;
    logic mreq_prev = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m[10] <= 10'd5;
            m[11] <= 10'd10;
        end
        if (bus.mem_req && !no_drop) begin
            lowcnt <= 2;
            if (bus.mem_we)
                m[bus.mem_addr] <= bus.mem_addr[0] ? bus.mem_wdata[19:10]
                                                   : bus.mem_wdata[9:0];
            else
                mrd <= {m[{bus.mem_addr[9:1], 1'b1}],
                        m[{bus.mem_addr[9:1], 1'b0}]};
        end else if (lowcnt > 0) begin
            lowcnt <= lowcnt - 1;
        end
        if (bus.mem_req) mreq_cnt <= mreq_cnt + 1;
        if (bus.mem_req && mreq_prev) mreq_double <= mreq_double + 1;
        mreq_prev <= bus.mem_req;
    end

    assign bus.mem_ready = !force_low && (lowcnt == 0);
    assign bus.mem_rdata = mrd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output int lat,
                            output logic [1:0] a, output logic [1:0] e,
                            output logic [19:0] r);
        bit got;
        got = 1'b0;
        lat = -1;
        a = 2'b00;
        e = 2'b00;
        r = 20'd0;
        for (int i = 1; i <= budget && !got; i++) begin
            tick();
            if (bus.ack != 2'b00) begin
                got = 1'b1;
                lat = i;
                a = bus.ack;
                e = bus.err;
                r = bus.rdata;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bus.ack, bus.err, bus.mem_req, bus.mem_we, bus.busy} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_ctl got %b want 0000000",
                     {bus.ack, bus.err, bus.mem_req, bus.mem_we, bus.busy});
        end
        vectors++;
        if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 50'd0) begin
            miscompares++;
            $display("FAIL reset_data got %h %h %h want 0",
                     bus.mem_addr, bus.mem_wdata, bus.rdata);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        int lat, p0;
        logic [1:0] a, e;
        logic [19:0] r;
        p0 = mreq_cnt;
        bus.req = 2'b01;
        bus.we = 2'b00;
        bus.addr0 = 10'd10;
        wait_ack(30, lat, a, e, r);
        bus.req = 2'b00;
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL rd_latency got %0d want 5", lat);
        end
        vectors++;
        if (a !== 2'b01 || e !== 2'b00) begin
            miscompares++;
            $display("FAIL rd_ack got %b/%b want 01/00", a, e);
        end
        vectors++;
        if (r !== 20'h02805) begin
            miscompares++;
            $display("FAIL rd_data got %h want 02805", r);
        end
        tick();
        vectors++;
        if (mreq_cnt - p0 !== 1) begin
            miscompares++;
            $display("FAIL rd_pulses got %0d want 1", mreq_cnt - p0);
        end
    endtask

    task automatic test_write_read();
        int lat;
        logic [1:0] a, e;
        logic [19:0] r;
        bus.req = 2'b10;
        bus.we = 2'b10;
        bus.addr1 = 10'd12;
        bus.wdata1 = 20'h00003;
        wait_ack(30, lat, a, e, r);
        bus.req = 2'b00;
        vectors++;
        if (lat !== 5 || a !== 2'b10 || e !== 2'b00) begin
            miscompares++;
            $display("FAIL wr_ack got lat %0d %b/%b want 5 10/00", lat, a, e);
        end
        vectors++;
        if (r !== 20'h02805) begin
            miscompares++;
            $display("FAIL wr_rdata_hold got %h want 02805", r);
        end
        tick();
        bus.req = 2'b10;
        bus.we = 2'b00;
        wait_ack(30, lat, a, e, r);
        bus.req = 2'b00;
        vectors++;
        if (a !== 2'b10 || r[9:0] !== 10'd3) begin
            miscompares++;
            $display("FAIL rdback got %b %h want 10 low 003", a, r);
        end
        tick();
    endtask

    task automatic test_contention();
        int lat;
        logic [1:0] a, e, exp_a;
        logic [19:0] r;
        int exp_lat;
        bus.we = 2'b00;
        bus.addr0 = 10'd10;
        bus.addr1 = 10'd12;
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_a = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_lat = (k == 0) ? 5 : 6;
            wait_ack(30, lat, a, e, r);
            vectors++;
            if (a !== exp_a || lat !== exp_lat) begin
                miscompares++;
                $display("FAIL rr_%0d got %b lat %0d want %b lat %0d",
                         k, a, lat, exp_a, exp_lat);
            end
        end
        bus.req = 2'b00;
        tick();
        vectors++;
        if (mreq_double !== 0) begin
            miscompares++;
            $display("FAIL mreq_double got %0d want 0", mreq_double);
        end
    endtask

    task automatic test_busy_mem();
        int lat, p0;
        logic [1:0] a, e;
        logic [19:0] r;
        p0 = mreq_cnt;
        force_low = 1'b1;
        bus.req = 2'b01;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (mreq_cnt - p0 !== 0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_hold got %0d/%b want 0/0",
                     mreq_cnt - p0, bus.busy);
        end
        force_low = 1'b0;
        wait_ack(30, lat, a, e, r);
        bus.req = 2'b00;
        vectors++;
        if (lat !== 5 || a !== 2'b01) begin
            miscompares++;
            $display("FAIL busy_lat got %0d %b want 5 01", lat, a);
        end
        tick();
    endtask

    task automatic test_timeout();
        int lat;
        logic [1:0] a, e;
        logic [19:0] r;
        no_drop = 1'b1;
        bus.req = 2'b10;
        bus.we = 2'b00;
        bus.addr1 = 10'd10;
        wait_ack(40, lat, a, e, r);
        bus.req = 2'b00;
        vectors++;
        if (lat !== 18) begin
            miscompares++;
            $display("FAIL to_latency got %0d want 18", lat);
        end
        vectors++;
        if (a !== 2'b10 || e !== 2'b10) begin
            miscompares++;
            $display("FAIL to_flags got %b/%b want 10/10", a, e);
        end
        vectors++;
        if (r !== 20'h02805) begin
            miscompares++;
            $display("FAIL to_rdata got %h want 02805", r);
        end
        no_drop = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        logic [1:0] a, e;
        logic [19:0] r;
        bus.req = 2'b10;
        bus.we = 2'b00;
        bus.addr1 = 10'd12;
        tick();
        tick();
        tick();
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy got %b want 1", bus.busy);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        vectors++;
        if ({bus.ack, bus.err, bus.mem_req, bus.mem_we, bus.busy,
             bus.mem_addr, bus.mem_wdata, bus.rdata} !== 57'd0) begin
            miscompares++;
            $display("FAIL mid_reset got %b %b %b %h %h want all 0",
                     bus.ack, bus.err, bus.busy, bus.mem_addr, bus.rdata);
        end
        bus.req = 2'b11;
        bus.addr0 = 10'd10;
        wait_ack(30, lat, a, e, r);
        bus.req = 2'b00;
        vectors++;
        if (lat !== 5 || a !== 2'b01) begin
            miscompares++;
            $display("FAIL post_reset got lat %0d %b want 5 01", lat, a);
        end
        tick();
    endtask

    initial begin
        bus.req = 2'b00;
        bus.we = 2'b00;
        bus.addr0 = 10'd0;
        bus.addr1 = 10'd0;
        bus.wdata0 = 20'd0;
        bus.wdata1 = 20'd0;
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_busy_mem();
        test_timeout();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
